// File: rtl/harvos_pkg.sv
// harvos_pkg: shared types for the harvos fetch path.
// Arbiter state encoding and instruction-memory data width.
package harvos_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_DRAIN
    } harvos_arb_state_e;

    localparam int HARVOS_IMEM_DW = 32;

endpackage

// File: rtl/harvos_rr_pick.sv
// harvos_rr_pick: combinational round-robin picker.
// Returns the first requester at or after ptr, wrapping modulo N.
module harvos_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Walk the ring from ptr and keep the first hit.
    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (req[j] && !any) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/harvos_imem_arb.sv
// harvos_imem_arb: round-robin instruction-memory port arbiter.
// One transaction in flight; a watchdog turns a silent slave into a fault.
module harvos_imem_arb
    import harvos_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          m_req,
    input  logic [N_REQ*AW-1:0]       m_addr,
    output logic [HARVOS_IMEM_DW-1:0] m_rdata,
    output logic [N_REQ-1:0]          m_rvalid,
    output logic [N_REQ-1:0]          m_fault,
    output logic                      s_req,
    output logic [AW-1:0]             s_addr,
    input  logic [HARVOS_IMEM_DW-1:0] s_rdata,
    input  logic                      s_rvalid,
    input  logic                      s_fault,
    output logic [N_REQ-1:0]          grant,
    output logic                      busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    harvos_arb_state_e state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             s_req_q, s_req_d;
    logic [AW-1:0]    s_addr_q, s_addr_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic [AW-1:0]    pick_addr;
    logic [CW-1:0]    cnt_sat;
    logic [IW-1:0]    ptr_adv;
    logic             to_hit;
    logic             resp;

    harvos_rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req (m_req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign pick_addr = m_addr[int'(pick_idx)*AW +: AW];
    assign cnt_sat   = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
    assign ptr_adv   = (int'(gidx_q) == N_REQ - 1) ? '0
                                                   : gidx_q + IW'(1);
    assign to_hit    = TO_EN && (cnt_q == TO_LAST);
    assign resp      = s_rvalid | s_fault;

    // Next-state, watchdog and response routing.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        s_req_d  = 1'b0;
        s_addr_d = s_addr_q;
        m_rvalid = '0;
        m_fault  = '0;
        m_rdata  = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d  = ARB_WAIT;
                    grant_d  = pick_gnt;
                    gidx_d   = pick_idx;
                    s_req_d  = 1'b1;
                    s_addr_d = pick_addr;
                    cnt_d    = '0;
                end
            end
            ARB_WAIT: begin
                m_rdata = s_rdata;
                cnt_d   = cnt_sat;
                if (resp) begin
                    m_rvalid = grant_q & {N_REQ{s_rvalid & ~s_fault}};
                    m_fault  = grant_q & {N_REQ{s_fault}};
                    state_d  = ARB_IDLE;
                    grant_d  = '0;
                    ptr_d    = ptr_adv;
                end else if (to_hit) begin
                    m_fault = grant_q;
                    state_d = ARB_DRAIN;
                    ptr_d   = ptr_adv;
                    cnt_d   = '0;
                end
            end
            ARB_DRAIN: begin
                cnt_d = cnt_sat;
                if (resp || to_hit) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            s_req_q  <= 1'b0;
            s_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            s_req_q  <= s_req_d;
            s_addr_q <= s_addr_d;
        end
    end

    assign s_req  = s_req_q;
    assign s_addr = s_addr_q;
    assign grant  = grant_q;
    assign busy   = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_harvos_imem_arb.sv
// tb_harvos_imem_arb: randomized bench with a cycle-level reference model.
// Directed phases first, then free-running random traffic.
`timescale 1ns/1ps
module tb_harvos_imem_arb;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_req;
    logic [N*AW-1:0] m_addr;
    logic [31:0]     m_rdata;
    logic [N-1:0]    m_rvalid;
    logic [N-1:0]    m_fault;
    logic            s_req;
    logic [AW-1:0]   s_addr;
    logic [31:0]     s_rdata;
    logic            s_rvalid;
    logic            s_fault;
    logic [N-1:0]    grant;
    logic            busy;

    always #5 clk = ~clk;

    harvos_imem_arb #(
        .N_REQ   (N),
        .AW      (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_rdata  (m_rdata),
        .m_rvalid (m_rvalid),
        .m_fault  (m_fault),
        .s_req    (s_req),
        .s_addr   (s_addr),
        .s_rdata  (s_rdata),
        .s_rvalid (s_rvalid),
        .s_fault  (s_fault),
        .grant    (grant),
        .busy     (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // reference model: 0 idle, 1 waiting on slave, 2 draining
    int            md_st  = 0;
    int            md_own = -1;
    int            md_ptr = 0;
    int            md_age = 0;
    logic          md_sreq = 1'b0;
    logic [AW-1:0] md_saddr = '0;

    // masters and slave behaviour
    logic [N-1:0]  req_v = '0;
    logic [AW-1:0] addr_a [N];
    logic [N-1:0]  mask = '0;
    int            req_pct = 0;
    int            dly_lo = 1, dly_hi = 1;
    int            fault_pct = 0;
    int            stray_pct = 0;
    bit            rnd_dly = 0;
    bit            fixed = 0;
    int            resp_at = -1;
    int            cyc = 0;

    // inputs seen at the most recent edge
    logic [N-1:0]  p_req = '0;
    logic [AW-1:0] p_addr [N];
    logic          p_srv = 1'b0;
    logic          p_sf = 1'b0;
    logic          p_rst = 1'b1;
    logic [N-1:0]  p_strobe = '0;
    logic [N-1:0]  last_dut_g = '0;

    task automatic advance();
        int g;
        int j;
        if (p_rst) begin
            md_st = 0; md_own = -1; md_ptr = 0; md_age = 0;
            md_sreq = 1'b0; md_saddr = '0;
            return;
        end
        md_sreq = 1'b0;
        case (md_st)
            0: begin
                g = -1;
                for (int k = 0; k < N; k++) begin
                    j = (md_ptr + k) % N;
                    if (p_req[j] && g < 0) g = j;
                end
                if (g >= 0) begin
                    md_own = g; md_saddr = p_addr[g];
                    md_sreq = 1'b1; md_age = 0; md_st = 1;
                end
            end
            1: begin
                if (p_srv || p_sf) begin
                    md_st = 0; md_ptr = (md_own + 1) % N; md_own = -1;
                end else if (md_age == TO - 1) begin
                    md_st = 2; md_ptr = (md_own + 1) % N; md_age = 0;
                end else begin
                    md_age++;
                end
            end
            default: begin
                if (p_srv || p_sf || md_age == TO - 1) begin
                    md_st = 0; md_own = -1;
                end else begin
                    md_age++;
                end
            end
        endcase
    endtask

    task automatic cycle(input bit do_rst);
        logic [N-1:0]  e_g;
        logic [N-1:0]  e_rv;
        logic [N-1:0]  e_ft;
        logic [31:0]   e_rd;
        logic          in_wait;
        logic          to_now;
        logic          rep;
        int            d;
        @(posedge clk);
        #1;
        advance();
        cyc++;
        rst = do_rst;
        for (int i = 0; i < N; i++) begin
            if (p_strobe[i]) begin
                req_v[i] = 1'b0;
            end else if (!req_v[i] && mask[i] &&
                         $urandom_range(99) < req_pct) begin
                req_v[i] = 1'b1;
                addr_a[i] = fixed ? 32'h100 + 32'(i * 16) : $urandom;
            end
        end
        if (md_sreq) begin
            if (rnd_dly)
                d = ($urandom_range(2) == 0) ? $urandom_range(40, 13)
                                             : $urandom_range(8, 1);
            else
                d = $urandom_range(dly_hi, dly_lo);
            resp_at = cyc + d;
        end
        s_rvalid = 1'b0;
        s_fault  = 1'b0;
        if (cyc == resp_at) begin
            resp_at = -1;
            if ($urandom_range(99) < fault_pct) begin
                s_fault  = 1'b1;
                s_rvalid = 1'($urandom_range(1));
            end else begin
                s_rvalid = 1'b1;
            end
        end else if (md_st == 0 && $urandom_range(99) < stray_pct) begin
            s_rvalid = 1'b1;
            s_fault  = 1'($urandom_range(1));
        end
        if (do_rst) resp_at = cyc + 1;
        s_rdata = fixed ? 32'hDEADBEEF : $urandom;
        m_req = req_v;
        for (int i = 0; i < N; i++) m_addr[i*AW +: AW] = addr_a[i];
        #1;
        e_g     = (md_st != 0 && md_own >= 0) ? N'(1 << md_own) : '0;
        in_wait = (md_st == 1);
        rep     = s_rvalid | s_fault;
        to_now  = in_wait && !rep && (md_age == TO - 1);
        e_rv    = (in_wait && s_rvalid && !s_fault) ? e_g : '0;
        e_ft    = (in_wait && (s_fault || to_now)) ? e_g : '0;
        e_rd    = in_wait ? s_rdata : '0;
        chk("grant", grant, e_g);
        chk("busy", busy, md_st != 0);
        chk("s_req", s_req, md_sreq);
        chk("s_addr", s_addr, md_saddr);
        chk("m_rvalid", m_rvalid, e_rv);
        chk("m_fault", m_fault, e_ft);
        chk("m_rdata", m_rdata, e_rd);
        if (p_rst) last_dut_g = '0;
        if (s_req === 1'b1) begin
            chk("fair", (grant == last_dut_g) && ((p_req & ~grant) != 0),
                1'b0);
            last_dut_g = grant;
        end
        p_req = m_req;
        for (int i = 0; i < N; i++) p_addr[i] = addr_a[i];
        p_srv = s_rvalid;
        p_sf = s_fault;
        p_rst = do_rst;
        p_strobe = e_rv | e_ft;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    task automatic knobs(input logic [N-1:0] mk, input int rp,
                         input int lo, input int hi, input int fp,
                         input int sp);
        mask = mk; req_pct = rp; dly_lo = lo; dly_hi = hi;
        fault_pct = fp; stray_pct = sp;
    endtask

    initial begin
        bit hit;
        rst = 1'b1;
        m_req = '0;
        m_addr = '0;
        s_rdata = '0;
        s_rvalid = 1'b0;
        s_fault = 1'b0;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = '0;
            p_addr[i] = '0;
        end

        // reset and idle with stray slave strobes
        knobs('0, 0, 1, 1, 0, 0);
        cycle(1'b1);
        cycle(1'b1);
        knobs('0, 0, 1, 1, 0, 50);
        run(6);

        // single master, fixed 3-cycle slave latency
        fixed = 1;
        knobs(2'b01, 100, 3, 3, 0, 0);
        run(24);
        fixed = 0;

        // contention between both masters
        knobs(2'b11, 100, 1, 4, 0, 0);
        run(60);

        // slave faults, with and without s_rvalid
        knobs(2'b11, 100, 1, 5, 100, 0);
        run(40);

        // timeout then late response swallowed in drain
        knobs(2'b11, 100, 20, 20, 0, 0);
        run(120);

        // drain exits on its own timer
        knobs(2'b11, 100, 36, 36, 0, 0);
        run(120);

        // response races the watchdog
        knobs(2'b11, 100, 14, 16, 0, 0);
        run(120);

        // reset in the middle of a wait
        knobs(2'b01, 100, 12, 12, 0, 0);
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            cycle(1'b0);
            if (md_st == 1 && md_age == 3) hit = 1;
        end
        chk("rst_wait_reached", hit, 1'b1);
        cycle(1'b1);
        run(30);

        // free-running random traffic
        rnd_dly = 1;
        knobs(2'b11, 40, 1, 1, 20, 10);
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(599) == 0);
            if ($urandom_range(199) == 0)
                mask = N'($urandom_range(3));
        end
        rnd_dly = 0;
        knobs('0, 0, 1, 1, 0, 0);
        run(60);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
